fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Parametrised successor of the core fetch unit: decouples instruction memory from the decoder through a DEPTH-word prefetch FIFO.
- Fetches sequential words at the fetch PC and presents an opcode word plus an argument word to the decoder.
- The decoder retires 0, 1 or 2 words per cycle; an ALU PC write flushes the queue and redirects fetch.
- Sits between the instruction memory port and the decoder; drives pc_out, ir_out and k16_out.

Parameters:
- DATA_W, 16, instruction word width (ir_out, k16_out, mem_rdata).
- ADDR_W, 16, PC and memory address width.
- DEPTH, 4, FIFO depth in words; power of two, minimum 2.
- RESET_PC, 0, value loaded into fetch PC and decode PC on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous reset, active low.
- mem_req  out  1  fetch request valid.
- mem_addr  out  ADDR_W  word address of the request (fetch PC).
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid; exactly one per granted request, any later cycle.
- mem_rdata  in  DATA_W  read data.
- pc_w  in  1  ALU redirect strobe.
- pc_alu  in  ADDR_W  redirect target.
- pop  in  2  words retired by the decoder this cycle (0, 1 or 2).
- pc_out  out  ADDR_W  address of the head word (decode PC).
- ir_out  out  DATA_W  head word.
- k16_out  out  DATA_W  word after the head.
- ir_valid  out  1  at least 1 word visible.
- k16_valid  out  1  at least 2 words visible.

Behaviour:
- State: fetch PC fpc, decode PC dpc, read/write pointers, count (0..DEPTH), outstanding flag out_f (at most one request in flight), discard flag.
- Reset (rst_n=0 at edge): fpc=dpc=RESET_PC, count=0, out_f=0, discard=0, pointers=0. Outputs after reset: ir_valid=0, k16_valid=0, pc_out=RESET_PC, mem_req=0 during the reset cycle.
- Reset mid-transaction: a late mem_rvalid for a pre-reset request is ignored (discard=0 and out_f=0, so no write occurs).
- Request rule: mem_req = rst_n & ~out_f & ~pc_w & (count + wr < DEPTH). mem_addr = fpc.
- On mem_gnt: fpc += 1 (wraps modulo 2^ADDR_W) and out_f=1.
- Response: on mem_rvalid, out_f=0.
  - If discard=1: the word is dropped and discard clears.
  - Otherwise wr=1 and the word is written at the write pointer.
- Visible words V = count (without the optional feature). ir_valid = V>=1; k16_valid = V>=2.
- ir_out and k16_out are the words at the read pointer and read pointer+1 (mod DEPTH). Their values are don't-care when the matching valid is 0.
- Pop legality: pop=1 is honoured only if ir_valid; pop=2 only if k16_valid; pop=3 is treated as 0. An illegal pop is ignored entirely, with no partial consume.
- Honoured pop p: read pointer += p, dpc += p (mod 2^ADDR_W), count += wr - p.
- Redirect (pc_w=1) has priority over everything:
  - fpc=dpc=pc_alu, count=0, pointers reset; pop and any same-cycle response word are ignored.
  - mem_req=0 this cycle.
  - discard is set iff out_f=1 and mem_rvalid=0 this cycle; otherwise discard=0.
- Back-to-back pc_w: each redirect reapplies; discard stays set while the stale response is still pending.
- Full: no request issues while count + wr = DEPTH. Because of this credit rule, overflow is impossible.
- Pointer wrap: modulo DEPTH, with no bubble at the wrap.
- Latency: redirect at cycle N → mem_req at N+1. The word becomes ir_valid the cycle after mem_rvalid.

Optional Feature:
- Macro: FETCH_QUEUE_BYPASS_EN.
- Defined:
  - V = count + (mem_rvalid & ~discard).
  - When the incoming word is the head or second word, it drives ir_out or k16_out combinationally in the same cycle and may be popped immediately.
  - Pointer and count arithmetic is unchanged (write then consume); an empty queue that receives and pops 1 stays at count=0.
  - The request rule uses count + wr - p < DEPTH.
- Undefined: V = count; data reaches the decoder one cycle after mem_rvalid.

Test Plan:
- Reset then gnt/rvalid every other cycle, pop=0 → mem_addr 0,1,2,3; after 4 words count=4, mem_req=0, ir_out=word@0, k16_out=word@1.
- Queue holds words A,B,C at dpc=0x0010; pop=2 → next cycle pc_out=0x0012, ir_out=C, k16_valid=0.
- pc_w=1, pc_alu=0x8000 with a request outstanding; stale rvalid arrives 2 cycles later → data dropped. First kept word is from 0x8000; pc_out=0x8000.
- pop=2 with only 1 word queued → no change to pc_out or count. Same with pop=3 and 2 words.
- DEPTH=4: fetch 10 words with continuous pop=1 → all words seen in order across pointer wrap, with no loss or duplication. fpc wraps from 0xFFFF to 0x0000 when started at 0xFFFE.
- FETCH_QUEUE_BYPASS_EN, empty queue, rvalid with 0x1234 → ir_valid=1 and ir_out=0x1234 in the same cycle; pop=1 there → count stays 0, pc_out advances by 1.

Source files
------------

// File: rtl/fetch_queue.sv
// Prefetch FIFO between instruction memory and decoder; one fetch in flight.
// Define FETCH_QUEUE_BYPASS_EN to forward the incoming word to the decoder same-cycle.
module fetch_queue #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH = 4,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              pc_w,
  input  logic [ADDR_W-1:0] pc_alu,
  input  logic [1:0]        pop,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] ir_out,
  output logic [DATA_W-1:0] k16_out,
  output logic              ir_valid,
  output logic              k16_valid
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [ADDR_W-1:0] fpc_q, fpc_d, dpc_q, dpc_d;
  logic [PW-1:0]     rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              out_q, out_d, disc_q, disc_d;
  logic [DATA_W-1:0] buf_q [DEPTH];

  logic              wr, fire;
  logic [1:0]        p;
  logic [CW:0]       vis, occ;
  logic [DATA_W-1:0] rd0, rd1;

  // A response only lands if it answers a live, non-stale request
  assign wr = mem_rvalid & out_q & ~disc_q;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign vis = {1'b0, cnt_q} + (CW+1)'(wr);
  assign occ = {1'b0, cnt_q} + (CW+1)'(wr) - (CW+1)'(p);
`else
  assign vis = {1'b0, cnt_q};
  assign occ = {1'b0, cnt_q} + (CW+1)'(wr);
`endif

  assign ir_valid  = vis != '0;
  assign k16_valid = vis >= (CW+1)'(2);

  always_comb begin
    p = 2'd0;
    unique case (1'b1)
      (pop == 2'd1) && ir_valid:  p = 2'd1;
      (pop == 2'd2) && k16_valid: p = 2'd2;
      default:                    p = 2'd0;
    endcase
  end

  assign mem_req  = rst_n & ~out_q & ~pc_w & (occ < (CW+1)'(DEPTH));
  assign fire     = mem_req & mem_gnt;
  assign mem_addr = fpc_q;
  assign pc_out   = dpc_q;

  assign rd0 = buf_q[rptr_q];
  assign rd1 = buf_q[rptr_q + PW'(1)];

`ifdef FETCH_QUEUE_BYPASS_EN
  assign ir_out  = (cnt_q == CW'(0)) ? mem_rdata : rd0;
  assign k16_out = (cnt_q == CW'(1)) ? mem_rdata : rd1;
`else
  assign ir_out  = rd0;
  assign k16_out = rd1;
`endif

  always_comb begin
    fpc_d  = fpc_q;
    dpc_d  = dpc_q;
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    out_d  = out_q;
    disc_d = disc_q;
    if (pc_w) begin
      fpc_d  = pc_alu;
      dpc_d  = pc_alu;
      rptr_d = '0;
      wptr_d = '0;
      cnt_d  = '0;
      // The in-flight word still arrives later and must be dropped
      out_d  = out_q & ~mem_rvalid;
      disc_d = out_q & ~mem_rvalid;
    end else begin
      if (mem_rvalid & out_q) begin
        out_d  = 1'b0;
        disc_d = 1'b0;
      end
      if (wr) wptr_d = wptr_q + PW'(1);
      rptr_d = rptr_q + PW'(p);
      dpc_d  = dpc_q + ADDR_W'(p);
      cnt_d  = cnt_q + CW'(wr) - CW'(p);
      if (fire) begin
        fpc_d = fpc_q + ADDR_W'(1);
        out_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fpc_q  <= ADDR_W'(RESET_PC);
      dpc_q  <= ADDR_W'(RESET_PC);
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      out_q  <= 1'b0;
      disc_q <= 1'b0;
    end else begin
      fpc_q  <= fpc_d;
      dpc_q  <= dpc_d;
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      disc_q <= disc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && wr && !pc_w) buf_q[wptr_q] <= mem_rdata;
  end

endmodule
